// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions: datapath width, instruction size,
// fetch FSM state encoding and the sequential next-PC helper.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  // Sequential PC step; the addition wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC mux: a redirect wins over the sequential +4 step; otherwise PC holds.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: a redirect to a target that
// is not word aligned is replaced by TRAP_VECTOR and flagged on misalign.
module pc_next
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc_nxt,
  output logic            misalign
);

`ifndef FETCH_MISALIGN_TRAP_EN
  // Trap address only matters when misalignment checking is built in.
  logic [XLEN-1:0] unused_trap;
  assign unused_trap = TRAP_VECTOR;
`endif

  // Select redirect target (or trap vector), sequential step, or hold.
  always_comb begin
    pc_nxt   = pc;
    misalign = 1'b0;
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_target[1:0] != 2'b00) begin
        pc_nxt   = TRAP_VECTOR;
        misalign = 1'b1;
      end else begin
        pc_nxt = redirect_target;
      end
`else
      pc_nxt = redirect_target;
`endif
    end else if (advance) begin
      pc_nxt = pc_incr(pc);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC and walks it through a
// single-outstanding-request instruction memory, one instruction per three
// cycles (REQ -> RESP -> HOLD). Redirects squash in-flight work via kill.
// Optional feature macro FETCH_MISALIGN_TRAP_EN enables misaligned-redirect
// trapping (see pc_next); without it misalign_err stays 0.
//
// Handshakes: a memory request transfers on a cycle where imem_req=1 and
// imem_gnt=1, and imem_req/imem_addr stay stable until then (a redirect may
// retarget it). A response transfers on any cycle with imem_rvalid=1 while a
// request is outstanding. A fetched instruction transfers to decode on a
// cycle with if_valid=1 and if_ready=1; if_valid/if_instr/if_pc stay stable
// until then unless a redirect squashes them.
module fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            if_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign_err
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic            kill;
  logic [XLEN-1:0] pc_nxt;
  logic            trap;
  logic            advance;

  // PC steps only when a live (non-killed) response is captured.
  assign advance   = (state == RESP) && imem_rvalid && !kill;
  assign imem_addr = pc;

  pc_next #(
    .TRAP_VECTOR(TRAP_VECTOR)
  ) u_pc_next (
    .pc             (pc),
    .advance        (advance),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .pc_nxt         (pc_nxt),
    .misalign       (trap)
  );

  // Fetch FSM with registered request, decode-side outputs and kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_VECTOR;
      kill         <= 1'b0;
      imem_req     <= 1'b0;
      if_valid     <= 1'b0;
      if_instr     <= '0;
      if_pc        <= '0;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      misalign_err <= trap;
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            // A redirect racing the grant leaves a stale response to drop.
            state    <= RESP;
            imem_req <= 1'b0;
            kill     <= redirect_valid;
          end
        end
        RESP: begin
          if (redirect_valid) begin
            if (imem_rvalid) begin
              state    <= REQ;
              imem_req <= 1'b1;
              kill     <= 1'b0;
            end else begin
              kill <= 1'b1;
            end
          end else if (imem_rvalid) begin
            if (kill) begin
              kill     <= 1'b0;
              state    <= REQ;
              imem_req <= 1'b1;
            end else begin
              if_instr <= imem_rdata;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          // A redirect squashes the held instruction even if decode takes it.
          if (redirect_valid || if_ready) begin
            if_valid <= 1'b0;
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by randomized traffic,
// checked against a program-order model of the fetch stream and a
// one-outstanding instruction memory model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        misalign_err;

  fetch_ctrl #(
    .RESET_VECTOR(RESET_VEC),
    .TRAP_VECTOR (TRAP_VEC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_ready       (if_ready),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .misalign_err   (misalign_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Model state
  logic [31:0] model_pc;      // address of next instruction in program order
  logic [31:0] exp_q[$];      // addresses of responses still owed by memory
  int          lat;
  int          lat_max;
  bit          exp_mis;
  bit          prev_req_hold, prev_vld_hold, prev_vld_drop;
  logic [31:0] prev_addr, prev_pc, prev_instr;
  int          idle_cyc;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Assert reset asynchronously, check reset values, release with a stray
  // response pending on the bus.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0; imem_rdata = '0;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_pc", imem_addr, RESET_VEC);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    model_pc = RESET_VEC;
    exp_q.delete();
    exp_mis = 1'b0;
    prev_req_hold = 1'b0; prev_vld_hold = 1'b0; prev_vld_drop = 1'b0;
    idle_cyc = 0;
  endtask

  // One clock cycle: check outputs against the model at the falling edge,
  // play the memory, update the model for the coming edge, drive inputs.
  task automatic step(input logic gnt_i, input logic rdy_i, input logic redir_i,
                      input logic [31:0] tgt_i);
    logic        rv;
    logic [31:0] rd;
    @(negedge clk);
    check("misalign_err", 32'(misalign_err), 32'(exp_mis));
    if (prev_req_hold) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, prev_addr);
    end
    if (prev_vld_hold) begin
      check("if_valid_held", 32'(if_valid), 32'd1);
      check("if_pc_held", if_pc, prev_pc);
      check("if_instr_held", if_instr, prev_instr);
    end
    if (prev_vld_drop) check("if_valid_drop", 32'(if_valid), 32'd0);
    if (imem_req) begin
      check("req_addr", imem_addr, model_pc);
      check("outstanding", 32'(exp_q.size()), 32'd0);
    end

    rv = 1'b0;
    rd = $urandom;
    if (exp_q.size() != 0) begin
      if (lat == 0) begin
        rv = 1'b1;
        rd = mem_word(exp_q.pop_front());
      end else begin
        lat--;
      end
    end

    idle_cyc++;
    if (if_valid && rdy_i && !redir_i) begin
      check("if_pc", if_pc, model_pc);
      check("if_instr", if_instr, mem_word(model_pc));
      model_pc = model_pc + 32'd4;
      idle_cyc = 0;
    end
    if (imem_req && gnt_i) begin
      exp_q.push_back(imem_addr);
      lat = $urandom_range(0, lat_max);
    end
    exp_mis = 1'b0;
    if (redir_i) begin
      if (TRAP_EN && tgt_i[1:0] != 2'b00) begin
        model_pc = TRAP_VEC;
        exp_mis = 1'b1;
      end else begin
        model_pc = tgt_i;
      end
      idle_cyc = 0;
    end
    if (idle_cyc > 60) begin
      check("progress_timeout", 32'(idle_cyc), 32'd0);
      idle_cyc = 0;
    end

    prev_req_hold = imem_req && !gnt_i && !redir_i;
    prev_addr     = imem_addr;
    prev_vld_hold = if_valid && !rdy_i && !redir_i;
    prev_vld_drop = if_valid && (rdy_i || redir_i);
    prev_pc       = if_pc;
    prev_instr    = if_instr;

    imem_gnt        = gnt_i;
    if_ready        = rdy_i;
    redirect_valid  = redir_i;
    redirect_target = tgt_i;
    imem_rvalid     = rv;
    imem_rdata      = rd;
  endtask

  task automatic random_run(input int cycles);
    logic        last_redir;
    logic        redir;
    logic [31:0] tgt;
    last_redir = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      redir = !last_redir && ($urandom_range(0, 15) == 0);
      tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 31) == 0) tgt = 32'hFFFF_FFF8;
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), redir, tgt);
      last_redir = redir;
    end
  endtask

  initial begin
    lat_max = 0;
    lat = 0;

    // Reset, then stalled grant: request stays up at address 0.
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    check("stray_rvalid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);
    check("stall_req", 32'(imem_req), 32'd1);
    check("stall_addr", imem_addr, 32'h0);

    // Back-to-back fetches at one instruction per three cycles.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, '0);
      check("seq_addr", imem_addr, 32'(k * 4));
      step(1'b1, 1'b1, 1'b0, '0);
      check("seq_resp_noreq", 32'(imem_req), 32'd0);
      step(1'b1, 1'b1, 1'b0, '0);
      check("seq_if_pc", if_pc, 32'(k * 4));
    end

    // Redirect coinciding with the grant for 0x4.
    do_reset();
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    check("race_addr", imem_addr, 32'h4);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("redir_addr", imem_addr, 32'h200);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check("redir_if_pc", if_pc, 32'h200);

    // Held instruction, then a redirect in HOLD alongside if_ready.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, '0);
      check("hold_valid", 32'(if_valid), 32'd1);
    end
    step(1'b0, 1'b1, 1'b1, 32'h40);
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check("squash_valid", 32'(if_valid), 32'd0);
    check("squash_addr", imem_addr, 32'h40);

    // PC wrap from the top of the address space.
    step(1'b1, 1'b1, 1'b0, '0);
    check("wrap_top_addr", imem_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b1, 32'h102);
    check("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect target.
    step(1'b0, 1'b1, 1'b0, '0);
    check("mis_pulse", 32'(misalign_err), 32'(TRAP_EN));
    check("mis_addr", imem_addr, TRAP_EN ? 32'h100 : 32'h102);
    step(1'b0, 1'b1, 1'b0, '0);
    check("mis_one_cycle", 32'(misalign_err), 32'd0);

    // Randomized traffic, reset mid-transaction, more traffic.
    lat_max = 3;
    random_run(1500);
    do_reset();
    step(1'b0, 1'b1, 1'b0, '0);
    check("stray_rvalid2", 32'(if_valid), 32'd0);
    check("restart_addr", imem_addr, RESET_VEC);
    random_run(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0100, SHALL be the PC loaded on a misaligned redirect (see REQ-024).
REQ-003 Port list SHALL be as follows; clock and reset are listed first.
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction memory request valid.
- imem_addr  out  32  request address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; earliest one cycle after grant.
- imem_rdata  in  32  response instruction word.
- if_valid  out  1  fetched instruction available to decode.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_ready  in  1  decode consumes the instruction this cycle.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_target  in  32  new PC (already computed as PC + ImmOp by execute).
- misalign_err  out  1  one-cycle pulse on a trapped misaligned redirect.

Function
REQ-004 The block SHALL hold the architectural fetch PC and sequence it against a one-outstanding-request memory interface.
REQ-005 FSM states SHALL be IDLE, REQ, RESP and HOLD; no other states are permitted.
REQ-006 IDLE SHALL transition to REQ unconditionally on the next cycle.
REQ-007 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc; on imem_gnt=1 the FSM SHALL go to RESP, otherwise it SHALL stay in REQ with the request held stable.
REQ-008 In RESP with imem_rvalid=1 and kill=0, the block SHALL capture if_instr=imem_rdata and if_pc=pc, set if_valid=1, set pc to pc+4 and go to HOLD.
REQ-009 In RESP with imem_rvalid=1 and kill=1, the block SHALL discard the data, clear kill and go to REQ.
REQ-010 In HOLD, if_valid, if_instr and if_pc SHALL stay stable until if_ready=1; the block SHALL then clear if_valid and go to REQ.
REQ-011 Best-case throughput SHALL be one instruction per 3 cycles (REQ, RESP, HOLD); no prefetch is performed.
REQ-012 pc+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-013 redirect_valid SHALL take priority over every other event in the same cycle, and pc SHALL load redirect_target on the next edge in every state.
REQ-014 A redirect in IDLE, or in REQ without imem_gnt, SHALL update pc and stay on or enter the normal path, with no kill.
REQ-015 A redirect in REQ coinciding with imem_gnt SHALL set kill=1 and go to RESP, so the old-address response is dropped.
REQ-016 A redirect in RESP without imem_rvalid SHALL set kill=1 and stay in RESP.
REQ-017 A redirect in RESP with imem_rvalid SHALL drop that data and go to REQ.
REQ-018 A redirect in HOLD SHALL clear if_valid next cycle and go to REQ, even if if_ready=1 the same cycle; the held instruction is considered squashed.
REQ-019 The block SHALL never have more than one request outstanding, and imem_req SHALL be 0 outside REQ.

Reset
REQ-020 While rst_n=0, state SHALL be IDLE, pc=RESET_VECTOR, imem_req=0, if_valid=0, if_instr=0, if_pc=0, kill=0 and misalign_err=0, asynchronously.
REQ-021 Reset asserted mid-transaction SHALL abandon any outstanding request, and responses arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-022 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-redirect checking.
REQ-023 Without the macro, redirect_target SHALL be used verbatim, and misalign_err SHALL be tied to 0.
REQ-024 With the macro, a redirect whose target[1:0]!=0 SHALL load pc=TRAP_VECTOR instead, and misalign_err SHALL pulse for exactly one cycle; kill handling is unchanged.

Structure
REQ-025 A shared package (riscv_pkg) SHALL hold the FSM state enum fetch_state_t and the constants XLEN=32 and INSTR_BYTES=4.
REQ-026 One sub-module, pc_next (next-PC mux: redirect/trap/+4), SHALL be instantiated; all else stays in fetch_ctrl.

Verification
REQ-027 Reset release, gnt=1 immediately, rvalid 1 cycle later, if_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8, with if_pc matching.
REQ-028 imem_gnt held 0 for 5 cycles in REQ -> imem_req=1 and imem_addr=0x0 stable throughout, and no state advance.
REQ-029 Redirect to 0x200 in the same cycle as a grant for 0x4 -> response for 0x4 dropped, next request is 0x200, and if_pc=0x200.
REQ-030 if_ready held 0 for 4 cycles, then redirect to 0x40 in HOLD with if_ready=1 -> if_valid falls, and the next fetch is 0x40.
REQ-031 Start with pc=0xFFFF_FFFC and fetch -> next imem_addr=0x0000_0000.
REQ-032 With FETCH_MISALIGN_TRAP_EN, redirect to 0x102 -> misalign_err pulses for 1 cycle and the next imem_addr=0x100; without the macro, the next imem_addr=0x102.
